bus_master_req_if: RTL and testbench

//  Master-side request/address front end of the system bus arbitration protocol.

---
 rtl/bus_master_req_if.sv | 133 +++++++++++++
 tb/tb_bus_master_req_if.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_master_req_if.sv
// Master-side arbitration front end: 2-cycle request strobe with serial slave id (MSB first),
// then waits for a settled grant and reports bus ownership until the datapath completes.
module bus_master_req_if #(
    parameter int SETTLE_CYCLES = 2,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req_valid,
    input  logic [1:0] req_slave,
    output logic       req_ready,
    output logic       m_request,
    output logic       m_slave_sel,
    input  logic       m_grant,
    input  logic       xfer_done,
    output logic       bus_owned,
    output logic [1:0] owned_slave,
    output logic       timeout_err,
    output logic       grant_lost
);

    localparam int CW = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] TMO    = CW'(GRANT_TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR_MSB = 3'd1;
    localparam logic [2:0] S_ADDR_LSB = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_OWN      = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          m_request_q, m_request_d;
    logic          m_slave_sel_q, m_slave_sel_d;
    logic          bus_owned_q, bus_owned_d;
    logic [1:0]    owned_slave_q, owned_slave_d;
    logic          timeout_err_q, timeout_err_d;
    logic          grant_lost_q, grant_lost_d;

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        m_request_d   = 1'b0;
        m_slave_sel_d = 1'b0;
        bus_owned_d   = bus_owned_q;
        owned_slave_d = owned_slave_q;
        timeout_err_d = 1'b0;
        grant_lost_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    id_d          = req_slave;
                    state_d       = S_ADDR_MSB;
                    m_request_d   = 1'b1;
                    m_slave_sel_d = req_slave[1];
                end
            end
            S_ADDR_MSB: begin
                state_d       = S_ADDR_LSB;
                m_request_d   = 1'b1;
                m_slave_sel_d = id_q[0];
            end
            S_ADDR_LSB: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // Grant is only trusted once the settle window has passed; it beats a coincident timeout.
                if (cnt_q >= SETTLE && m_grant) begin
                    state_d       = S_OWN;
                    bus_owned_d   = 1'b1;
                    owned_slave_d = id_q;
                end else if (cnt_inc == TMO) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            S_OWN: begin
                if (xfer_done) begin
                    state_d     = S_IDLE;
                    bus_owned_d = 1'b0;
                end else if (!m_grant) begin
                    state_d      = S_IDLE;
                    bus_owned_d  = 1'b0;
                    grant_lost_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                bus_owned_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            id_q          <= 2'b00;
            cnt_q         <= '0;
            m_request_q   <= 1'b0;
            m_slave_sel_q <= 1'b0;
            bus_owned_q   <= 1'b0;
            owned_slave_q <= 2'b00;
            timeout_err_q <= 1'b0;
            grant_lost_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            m_request_q   <= m_request_d;
            m_slave_sel_q <= m_slave_sel_d;
            bus_owned_q   <= bus_owned_d;
            owned_slave_q <= owned_slave_d;
            timeout_err_q <= timeout_err_d;
            grant_lost_q  <= grant_lost_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign m_request   = m_request_q;
    assign m_slave_sel = m_slave_sel_q;
    assign bus_owned   = bus_owned_q;
    assign owned_slave = owned_slave_q;
    assign timeout_err = timeout_err_q;
    assign grant_lost  = grant_lost_q;

endmodule

// File: tb/tb_bus_master_req_if.sv
// Scoreboard bench: each scenario pushes the expected output vector for a cycle, drives inputs,
// then pops and compares it 1 ns after the clock edge.
module tb_bus_master_req_if;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_slave = 2'b00;
    logic       m_grant = 1'b0;
    logic       xfer_done = 1'b0;
    logic       req_ready, m_request, m_slave_sel, bus_owned, timeout_err, grant_lost;
    logic [1:0] owned_slave;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] vec;      // {m_request, m_slave_sel, bus_owned, timeout_err, grant_lost, req_ready}
        logic       ck_slv;
        logic [1:0] slv;
    } exp_t;
    exp_t sb[$];

    bus_master_req_if #(.SETTLE_CYCLES(2), .GRANT_TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_slave(req_slave), .req_ready(req_ready),
        .m_request(m_request), .m_slave_sel(m_slave_sel), .m_grant(m_grant),
        .xfer_done(xfer_done), .bus_owned(bus_owned), .owned_slave(owned_slave),
        .timeout_err(timeout_err), .grant_lost(grant_lost)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic push(input logic req, input logic sel, input logic own, input logic tmo,
                        input logic gl, input logic rdy, input logic ck, input logic [1:0] slv);
        exp_t e;
        e.vec = {req, sel, own, tmo, gl, rdy};
        e.ck_slv = ck;
        e.slv = slv;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag);
        exp_t e;
        logic [5:0] got;
        got = {m_request, m_slave_sel, bus_owned, timeout_err, grant_lost, req_ready};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty, outputs %b", tag, got);
        end else begin
            e = sb.pop_front();
            if (got !== e.vec) begin
                errors++;
                $display("FAIL %s req/sel/own/tmo/gl/rdy got %b exp %b", tag, got, e.vec);
            end
            if (e.ck_slv) begin
                checks++;
                if (owned_slave !== e.slv) begin
                    errors++;
                    $display("FAIL %s owned_slave got %b exp %b", tag, owned_slave, e.slv);
                end
            end
        end
    endtask

    task automatic cyc(input logic rv, input logic [1:0] rs, input logic g, input logic xd, input string tag);
        req_valid = rv;
        req_slave = rs;
        m_grant   = g;
        xfer_done = xd;
        @(posedge sys_clk);
        #1;
        chk(tag);
    endtask

    // Accept id at edge A and run the two address cycles plus entry into WAIT_GRANT (edge A+2).
    task automatic do_addr(input logic [1:0] id, input logic g, input string tag);
        push(1, id[1], 0, 0, 0, 0, 0, 2'b00); cyc(1, id, g, 0, {tag, "_msb"});
        push(1, id[0], 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, g, 0, {tag, "_lsb"});
        push(0, 0, 0, 0, 0, 0, 0, 2'b00);     cyc(0, 2'b00, g, 0, {tag, "_wait0"});
    endtask

    task automatic test_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        push(0, 0, 0, 0, 0, 1, 1, 2'b00); chk("reset_vals");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 0, 0, "reset_idle");
    endtask

    task automatic test_basic_grant();
        do_addr(2'b10, 0, "basic");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, "basic_a3");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, "basic_a4");
        push(0, 0, 1, 0, 0, 0, 1, 2'b10); cyc(0, 2'b00, 1, 0, "basic_own");
        push(0, 0, 1, 0, 0, 0, 1, 2'b10); cyc(0, 2'b00, 1, 0, "basic_own_hold");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 1, 1, "basic_done");
    endtask

    task automatic test_stale_grant();
        do_addr(2'b01, 1, "stale");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "stale_a3_masked");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "stale_a4_masked");
        push(0, 0, 1, 0, 0, 0, 1, 2'b01); cyc(0, 2'b00, 1, 0, "stale_a5_own");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 1, 1, "stale_done");
    endtask

    task automatic test_timeout();
        do_addr(2'b11, 0, "tmo");
        for (int i = 1; i < 16; i++) begin
            push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, $sformatf("tmo_wait%0d", i));
        end
        push(0, 0, 0, 1, 0, 1, 0, 2'b00); cyc(0, 2'b00, 0, 0, "tmo_pulse");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 0, 0, "tmo_pulse_end");
    endtask

    task automatic test_grant_at_timeout();
        do_addr(2'b10, 0, "gtmo");
        for (int i = 1; i < 16; i++) begin
            push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, $sformatf("gtmo_wait%0d", i));
        end
        push(0, 0, 1, 0, 0, 0, 1, 2'b10); cyc(0, 2'b00, 1, 0, "gtmo_grant_wins");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 1, 1, "gtmo_done");
    endtask

    task automatic test_grant_lost();
        do_addr(2'b00, 1, "gl");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "gl_a3");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "gl_a4");
        push(0, 0, 1, 0, 0, 0, 1, 2'b00); cyc(0, 2'b00, 1, 0, "gl_own");
        push(0, 0, 0, 0, 1, 1, 0, 2'b00); cyc(0, 2'b00, 0, 0, "gl_pulse");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 0, 0, "gl_pulse_end");
        do_addr(2'b11, 1, "gl2");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "gl2_a3");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "gl2_a4");
        push(0, 0, 1, 0, 0, 0, 1, 2'b11); cyc(0, 2'b00, 1, 0, "gl2_own");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 0, 1, "gl2_done_wins");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 0, 0, "gl2_no_pulse");
    endtask

    task automatic test_reset_mid();
        push(1, 1, 0, 0, 0, 0, 0, 2'b00); cyc(1, 2'b11, 0, 0, "rst_msb");
        push(1, 1, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, "rst_lsb");
        sys_rst = 1'b1;
        #2;
        push(0, 0, 0, 0, 0, 1, 1, 2'b00); chk("rst_async");
        #2;
        sys_rst = 1'b0;
        do_addr(2'b01, 1, "rst_new");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "rst_new_a3");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 1, 0, "rst_new_a4");
        push(0, 0, 1, 0, 0, 0, 1, 2'b01); cyc(0, 2'b00, 1, 0, "rst_new_own");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(0, 2'b00, 1, 1, "rst_new_done");
    endtask

    task automatic test_back_to_back();
        do_addr(2'b10, 0, "b2b");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(1, 2'b01, 0, 0, "b2b_ign_wait");
        push(0, 0, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, "b2b_a4");
        push(0, 0, 1, 0, 0, 0, 1, 2'b10); cyc(0, 2'b00, 1, 0, "b2b_own");
        push(0, 0, 1, 0, 0, 0, 1, 2'b10); cyc(1, 2'b01, 1, 0, "b2b_ign_own");
        push(0, 0, 0, 0, 0, 1, 0, 2'b00); cyc(1, 2'b11, 1, 1, "b2b_done_ign");
        push(1, 1, 0, 0, 0, 0, 0, 2'b00); cyc(1, 2'b11, 0, 0, "b2b_accept");
        push(1, 1, 0, 0, 0, 0, 0, 2'b00); cyc(0, 2'b00, 0, 0, "b2b_lsb");
        sys_rst = 1'b1;
        #2;
        sys_rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_stale_grant();
        test_timeout();
        test_grant_at_timeout();
        test_grant_lost();
        test_reset_mid();
        test_back_to_back();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain left %0d expect %0d", sb.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
